// File: rtl/credit_rx_buffer.sv
// Receive side of the per-port credit link: one FWFT FIFO per port, one credit pulse per popped flit.
// Optional build macro CREDIT_RX_OVF_CHECK_EN adds a sticky per-port overflow flag.
module credit_rx_buffer #(
  parameter int NUM_PORTS  = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 32,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS-1:0]          credit_out,
  output logic [NUM_PORTS*CNT_W-1:0]    occupancy,
  output logic [NUM_PORTS-1:0]          ovf_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              credit_q;
    logic              full, push, pop;

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = (count_q != '0) & out_ready[gi];
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign push = in_valid[gi] & (~full | pop);

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        credit_q <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        credit_q <= pop;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data[gi*DATA_W +: DATA_W];
    end

    assign out_valid[gi]                    = (count_q != '0);
    assign out_data[gi*DATA_W +: DATA_W]    = mem_q[rd_ptr_q];
    assign occupancy[gi*CNT_W +: CNT_W]     = count_q;
    assign credit_out[gi]                   = credit_q;

`ifdef CREDIT_RX_OVF_CHECK_EN
    logic ovf_q;
    logic viol;

    assign viol = in_valid[gi] & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else if (viol) ovf_q <= 1'b1;
    end

    assign ovf_err[gi] = ovf_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (rst_n && viol) $error("credit_rx_buffer: overflow on port %0d", gi);
    end
`endif
`else
    assign ovf_err[gi] = 1'b0;
`endif
  end

endmodule
